deserializer_unit_cell: RTL and testbench

- Receive-side counterpart of the serializer unit cell.
- Samples one serial bit per CLK, hunts for a sync word to find frame alignment, then emits aligned WIDTH-bit parallel words with a one-cycle valid strobe.
- Sits at the far end of the serial link; its PAR_OUT must reproduce the serializer's PAR_IN words bit-for-bit.

---
 rtl/deserializer_unit_cell.sv | 203 ++++++++++++++++++++
 tb/tb_deserializer_unit_cell.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_unit_cell.sv
// deserializer_unit_cell
// Receive side of the serial link. It samples one bit per enabled CLK edge,
// LSB first, and hunts for SYNC_WORD to find frame alignment. Once aligned it
// emits WIDTH-bit data words on PAR_OUT with a one-cycle PAR_VALID strobe.
// Marker frames (SYNC_WORD) re-seen while locked are absorbed, not emitted.
//
// Optional build macro: DESER_LOCK_LOSS_EN
//   When defined, a frame-since-sync counter is built. A data frame that would
//   push the count past SYNC_INTERVAL is dropped, lock is released
//   (LOCK_LOST pulses) and hunting restarts from an empty window.
//   When undefined, LOCK_LOST is tied low and lock is only lost via RESET.
module deserializer_unit_cell #(
  parameter int unsigned       WIDTH         = 32,
  parameter logic [WIDTH-1:0]  SYNC_WORD     = WIDTH'(32'hC5AF_C5AF),
  parameter int unsigned       SYNC_INTERVAL = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             LOCKED,
  output logic             LOCK_LOST
);

  localparam int unsigned       FILL_W    = $clog2(WIDTH + 1);
  localparam int unsigned       BCNT_W    = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_win;
  logic [WIDTH-1:0]   w_nxt;
  logic [FILL_W-1:0]  r_fill;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [WIDTH-1:0]   r_par_out;
  logic               r_par_valid;

  logic               w_full;
  logic               w_sync_hit;
  logic               w_frame_end;
  logic               w_marker;
  logic               w_overrun;
  logic               w_emit;
  logic               w_lost;

  // Window as it will look after this edge; all match decisions use it so the
  // bit being sampled now is part of the comparison.
  assign w_nxt       = {SERIAL_IN, r_win[WIDTH-1:1]};
  // The window counts as full on the edge that samples the WIDTH-th bit.
  assign w_full      = (r_fill >= FILL_LAST);
  assign w_sync_hit  = (w_nxt == SYNC_WORD);
  assign w_frame_end = (r_bcnt == BCNT_LAST);
  assign w_marker    = w_frame_end && w_sync_hit;

`ifdef DESER_LOCK_LOSS_EN
  localparam int unsigned      FSS_W   = $clog2(SYNC_INTERVAL + 2);
  localparam logic [FSS_W-1:0] FSS_MAX = FSS_W'(SYNC_INTERVAL);

  logic [FSS_W-1:0] r_fss;
  logic             r_lock_lost;

  // A data frame arriving with SYNC_INTERVAL frames already counted overruns.
  assign w_overrun = (r_fss == FSS_MAX);

  // Frames since last marker: held at zero while hunting, cleared by markers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fss <= '0;
    end else if (ENABLE) begin
      if (r_state == ST_HUNT) begin
        r_fss <= '0;
      end else if (w_frame_end) begin
        if (w_marker) begin
          r_fss <= '0;
        end else if (!w_overrun) begin
          r_fss <= r_fss + FSS_W'(1);
        end
      end
    end
  end

  // Lock-loss strobe: one cycle after the overrunning frame edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= w_lost;
    end
  end

  assign LOCK_LOST = r_lock_lost;
`else
  assign w_overrun = 1'b0;
  assign LOCK_LOST = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: lock on a full-window sync match, release on overrun.
  always_comb begin
    w_state_nxt = r_state;
    if (ENABLE) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_full && w_sync_hit) begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_frame_end && !w_marker && w_overrun) begin
            w_state_nxt = ST_HUNT;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // Frame outcome: emit a data word, or drop it and report lock loss.
  always_comb begin
    w_emit = 1'b0;
    w_lost = 1'b0;
    if (ENABLE && (r_state == ST_LOCKED) && w_frame_end && !w_marker) begin
      if (w_overrun) begin
        w_lost = 1'b1;
      end else begin
        w_emit = 1'b1;
      end
    end
  end

  // Shift window: newest bit enters at the MSB, so the first bit ends at [0].
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_win <= '0;
    end else if (ENABLE) begin
      r_win <= w_nxt;
    end
  end

  // Fill count: bits sampled since reset or since lock loss, saturating.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fill <= '0;
    end else if (ENABLE) begin
      if (w_lost) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // Bit position within the frame; parked at zero while hunting so the first
  // bit after the sync word is bit 0 of the next frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bcnt <= '0;
    end else if (ENABLE) begin
      if ((r_state == ST_HUNT) || w_frame_end) begin
        r_bcnt <= '0;
      end else begin
        r_bcnt <= r_bcnt + BCNT_W'(1);
      end
    end
  end

  // Parallel output register and valid strobe. The strobe is rewritten every
  // edge (enabled or not) so it can never stretch past one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
    end else begin
      r_par_valid <= w_emit;
      if (w_emit) begin
        r_par_out <= w_nxt;
      end
    end
  end

  assign PAR_OUT   = r_par_out;
  assign PAR_VALID = r_par_valid;
  assign LOCKED    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_deserializer_unit_cell.sv
// Testbench for deserializer_unit_cell. A bit-queue model of the link runs
// alongside the DUT and every cycle's outputs are compared against it; directed
// sequences add literal expectations. Build with DESER_LOCK_LOSS_EN defined to
// also exercise lock loss (the main DUT then uses SYNC_INTERVAL = 4).
module tb_deserializer_unit_cell;

  localparam int          W    = 32;
  localparam logic [31:0] SYNC = 32'hC5AF_C5AF;
`ifdef DESER_LOCK_LOSS_EN
  localparam int SI = 4;
  localparam bit LL = 1'b1;
`else
  localparam int SI = 16;
  localparam bit LL = 1'b0;
`endif

  logic        CLK       = 1'b0;
  logic        RESET     = 1'b1;
  logic        ENABLE    = 1'b0;
  logic        SERIAL_IN = 1'b0;

  logic [31:0] par_out;
  logic        par_valid, locked, lock_lost;
  logic [31:0] z_par_out;
  logic        z_par_valid, z_locked, z_lock_lost;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int n_lost   = 0;

  always #5 CLK = ~CLK;

  deserializer_unit_cell #(
    .WIDTH(W), .SYNC_WORD(SYNC), .SYNC_INTERVAL(SI)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SERIAL_IN(SERIAL_IN),
    .PAR_OUT(par_out), .PAR_VALID(par_valid), .LOCKED(locked), .LOCK_LOST(lock_lost)
  );

  // Second instance with an all-zero sync word, used for the fill-count check.
  deserializer_unit_cell #(
    .WIDTH(W), .SYNC_WORD(32'h0000_0000), .SYNC_INTERVAL(16)
  ) u_dut0 (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SERIAL_IN(SERIAL_IN),
    .PAR_OUT(z_par_out), .PAR_VALID(z_par_valid), .LOCKED(z_locked), .LOCK_LOST(z_lock_lost)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          q_hist[$];
  bit          q_frame[$];
  bit          m_locked = 1'b0;
  int          m_fss    = 0;
  logic [31:0] e_par_out = '0;
  bit          e_valid  = 1'b0;
  bit          e_lost   = 1'b0;

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] w = '0;
    for (int i = 0; i < q.size() && i < 32; i++) w[i] = q[i];
    return w;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    logic [31:0] word;
    if (RESET) begin
      q_hist.delete(); q_frame.delete();
      m_locked = 1'b0; m_fss = 0; e_par_out = '0; e_valid = 1'b0; e_lost = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_lost  = 1'b0;
      if (ENABLE) begin
        q_hist.push_back(SERIAL_IN);
        if (q_hist.size() > W) void'(q_hist.pop_front());
        if (!m_locked) begin
          if (q_hist.size() == W && pack(q_hist) == SYNC) begin
            m_locked = 1'b1;
            q_frame.delete();
            m_fss = 0;
          end
        end else begin
          q_frame.push_back(SERIAL_IN);
          if (q_frame.size() == W) begin
            word = pack(q_frame);
            q_frame.delete();
            if (word == SYNC) begin
              m_fss = 0;
            end else if (LL && m_fss == SI) begin
              m_locked = 1'b0;
              e_lost   = 1'b1;
              q_hist.delete();
            end else begin
              e_par_out = word;
              e_valid   = 1'b1;
              m_fss++;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("m_locked",    locked,    m_locked);
    chk("m_par_valid", par_valid, e_valid);
    chk("m_par_out",   par_out,   e_par_out);
    chk("m_lock_lost", lock_lost, e_lost);
    if (par_valid) n_pulses++;
    if (lock_lost) n_lost++;
  end

  // ---------------- stimulus ----------------
  // Called at a negedge: drive the bit, return after the edge that sampled it.
  task automatic tick_bit(input bit b);
    SERIAL_IN = b;
    @(negedge CLK);
  endtask

  task automatic send_bits(input logic [31:0] w, input int first, input int n);
    logic [31:0] v;
    v = w;
    for (int i = first; i < first + n; i++) tick_bit(v[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 0, 32);
  endtask

  task automatic do_reset();
    #1 RESET = 1'b1;
    @(negedge CLK);
    #1 RESET = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          n0, l0;
    logic [31:0] w;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_par_out",   par_out,   32'h0);
    chk("rst_par_valid", par_valid, 1'b0);
    chk("rst_locked",    locked,    1'b0);
    chk("rst_lock_lost", lock_lost, 1'b0);
    #1 RESET = 1'b0;
    // ENABLE low: nothing moves
    repeat (3) tick_bit(1'b1);
    chk("dis_locked", locked, 1'b0);

    // Zero sync word: lock only once 32 bits have been sampled
    ENABLE = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick_bit(1'b0);
      if (i == 31) chk("zero_lock_at_31", z_locked, 1'b0);
      if (i == 32) chk("zero_lock_at_32", z_locked, 1'b1);
    end
    chk("zero_no_valid", z_par_valid, 1'b0);
    chk("zero_main_unlocked", locked, 1'b0);

    // Basic lock + one data word
    do_reset();
    n0 = n_pulses;
    send_bits(SYNC, 0, 31);
    chk("t1_lock_before", locked, 1'b0);
    send_bits(SYNC, 31, 1);
    chk("t1_lock_after", locked, 1'b1);
    send_word(32'h0000_C5AF);
    chk("t1_valid",   par_valid, 1'b1);
    chk("t1_par_out", par_out,   32'h0000_C5AF);
    tick_bit(1'b0);
    chk("t1_valid_drop", par_valid, 1'b0);
    #1 chk("t1_pulses", n_pulses - n0, 1);

    // Random prefix, then data words interleaved with markers
    do_reset();
    n0 = n_pulses;
    for (int i = 0; i < 5; i++) tick_bit(1'($urandom));
    send_word(SYNC);
    chk("t2_locked", locked, 1'b1);
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      if (w == SYNC) w = w ^ 32'h1;
      send_word(w);
      chk("t2_valid",   par_valid, 1'b1);
      chk("t2_par_out", par_out,   w);
      send_word(SYNC);
      chk("t2_marker_no_valid", par_valid, 1'b0);
      chk("t2_marker_hold",     par_out,   w);
    end
    #1 chk("t2_pulses", n_pulses - n0, 10);

    // ENABLE low for 7 cycles mid-word
    do_reset();
    send_word(SYNC);
    n0 = n_pulses;
    send_bits(32'hDEAD_BEEF, 0, 16);
    ENABLE = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk("t4_pause_valid",  par_valid, 1'b0);
      chk("t4_pause_locked", locked,    1'b1);
    end
    ENABLE = 1'b1;
    send_bits(32'hDEAD_BEEF, 16, 15);
    chk("t4_not_early", par_valid, 1'b0);
    send_bits(32'hDEAD_BEEF, 31, 1);
    chk("t4_valid",   par_valid, 1'b1);
    chk("t4_par_out", par_out,   32'hDEAD_BEEF);
    #1 chk("t4_pulses", n_pulses - n0, 1);

    // RESET at bit 17 of a frame
    do_reset();
    send_word(SYNC);
    send_bits(32'h1234_5678, 0, 17);
    #1 RESET = 1'b1;
    #1;
    chk("t5_rst_locked", locked,    1'b0);
    chk("t5_rst_valid",  par_valid, 1'b0);
    @(negedge CLK);
    #1 RESET = 1'b0;
    send_bits(32'h1234_5678, 17, 15);
    send_word(32'hA5A5_0F0F);
    chk("t5_no_relock", locked, 1'b0);
    send_word(SYNC);
    chk("t5_relock", locked, 1'b1);
    send_word(32'h1357_9BDF);
    chk("t5_valid",   par_valid, 1'b1);
    chk("t5_par_out", par_out,   32'h1357_9BDF);

`ifdef DESER_LOCK_LOSS_EN
    // Lock loss after SYNC_INTERVAL data frames without a marker
    do_reset();
    send_word(SYNC);
    n0 = n_pulses;
    l0 = n_lost;
    for (int k = 0; k < 5; k++) send_word(32'h0101_0000 + 32'(k));
    chk("t6_unlocked",  locked,    1'b0);
    chk("t6_lost",      lock_lost, 1'b1);
    chk("t6_no_valid",  par_valid, 1'b0);
    chk("t6_last_word", par_out,   32'h0101_0003);
    tick_bit(1'b0);
    chk("t6_lost_drop", lock_lost, 1'b0);
    #1;
    chk("t6_pulses", n_pulses - n0, 4);
    chk("t6_lost_n", n_lost - l0,   1);
`else
    l0 = n_lost;
    #1 chk("no_lock_lost", l0, 0);
`endif

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
